alu_mult_seq: RTL and testbench
===============================

Name: alu_mult_seq

Overview:
- Multi-cycle sequencer that runs MIPS MULT/MULTU on the shared 32-bit ALU, one iteration per cycle, and owns the HI/LO registers.
- Sits beside the execute stage. The ALU stays external so the core can reuse it when this block is idle.
- Drives ALU operands, select and carry-in; consumes the ALU sum, carry-out and overflow.

Parameters:
- WIDTH, 32, operand width; must match the ALU width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- start  in  1  request a multiply; sampled only in IDLE.
- is_signed  in  1  1 = MULT (Booth radix-2), 0 = MULTU (shift-add); captured with start.
- op_a  in  WIDTH  multiplicand; captured with start.
- op_b  in  WIDTH  multiplier; captured with start.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when hi/lo have been updated.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- alu_a  out  WIDTH  ALU operand a.
- alu_b  out  WIDTH  ALU operand b.
- alu_s  out  3  ALU select.
- alu_cin  out  1  ALU carry-in.
- alu_d  in  WIDTH  ALU result.
- alu_cout  in  1  ALU carry-out.
- alu_v  in  1  ALU overflow (Cout xor carry into MSB).

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - State goes to IDLE; busy=0, done=0, hi=0, lo=0.
  - alu_a=0, alu_b=0, alu_s=3'b111, alu_cin=0.
  - Working registers and counter cleared.
- ALU select codes used: 3'b010 add (a+b+cin), 3'b011 subtract (a+~b+1, cin=1), 3'b111 zero/idle.
- IDLE:
  - ALU outputs held at idle values.
  - If start=1: latch M=op_a, P_HI=0, P_LO=op_b, q=0, cnt=0, signed flag; go to CALC.
- CALC (exactly WIDTH cycles; cnt increments each cycle):
  - Unsigned:
    - alu_a=P_HI, alu_b = P_LO[0] ? M : 0, alu_s=010, cin=0.
    - Next {P_HI,P_LO} = {alu_cout, alu_d, P_LO} >> 1.
  - Signed Booth, decode {P_LO[0], q}:
    - 01: add M (alu_s=010, cin=0).
    - 10: subtract M (alu_s=011, cin=1).
    - 00/11: alu_b=0, alu_s=010, cin=0.
    - Shift in top bit t = alu_d[WIDTH-1] ^ alu_v, so 33-bit intermediates stay correct.
    - Next {P_HI,P_LO,q} = {t, alu_d, P_LO} >> 1.
  - After the cycle with cnt==WIDTH-1: go to WRITE.
- WRITE (one cycle):
  - hi<=P_HI, lo<=P_LO; done=1 this cycle only; ALU outputs at idle values.
  - Next state IDLE.
- Handshake and latency:
  - busy is high in CALC, ACC and WRITE.
  - hi/lo keep their previous values until WRITE.
  - start at edge k gives done high in cycle k+WIDTH+1 (33 cycles for WIDTH=32).
- Boundaries:
  - start while busy is ignored; no queueing.
  - start in the WRITE cycle is ignored.
  - start in the cycle after done is accepted (back-to-back issue).
  - Operand inputs are ignored after capture.
  - 0x80000000 signed cases must be correct; this relies on the alu_v correction.

Optional Feature:
- Macro MULT_ACCUM_EN.
- When defined:
  - Extra input acc (1 bit, captured with start) selects MADD/MADDU: {hi,lo} += product.
  - Two extra states sit between CALC and WRITE:
    - ACC_LO: alu_a=P_LO, alu_b=lo, alu_s=010, cin=0; latch P_LO=alu_d and carry c=alu_cout.
    - ACC_HI: alu_a=P_HI, alu_b=hi, alu_s=010, cin=c; latch P_HI=alu_d.
  - With acc=1, latency is WIDTH+3 cycles; with acc=0, ACC states are skipped.
- When undefined: no acc port, no ACC states, latency always WIDTH+1.

Decomposition:
- Shared package/include holds:
  - ALU select constants: ALU_ADD=3'b010, ALU_SUB=3'b011, ALU_ZERO=3'b111.
  - State encoding: IDLE, CALC, ACC_LO, ACC_HI, WRITE.
- Same constants are reused by the execute-stage decoder.
- No sub-module; single FSM plus datapath registers.
- Bench instantiates the existing ALU and connects it to the alu_* ports.

Test Plan:
- Unsigned 7*6, start pulsed once -> busy for 33 cycles, done in cycle 33, hi=0, lo=42.
- Unsigned 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- Signed cases:
  - -3*5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
  - 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
  - -1*-1 -> hi=0, lo=1.
- Busy and back-to-back:
  - start re-asserted with new operands at cycle 10 of a run -> ignored; result matches first operands.
  - Next start issued in the cycle after done -> accepted.
- rst_n low at CALC cycle 15 -> immediately busy=0, hi=lo=0, alu_s=111; a fresh start afterwards computes correctly.
- MULT_ACCUM_EN, acc=1:
  - hi=0, lo=0xFFFFFFFF, unsigned 1*1 -> hi=1, lo=0 after 35 cycles.
  - hi=0, lo=5, 2*3 -> lo=11.

Source files
------------

// File: rtl/alu_mult_seq_pkg.sv
// Shared ALU select codes and sequencer state encoding for alu_mult_seq.
// The execute-stage decoder imports the same ALU select constants.
package alu_mult_seq_pkg;

   localparam logic [2:0] ALU_ADD  = 3'b010;
   localparam logic [2:0] ALU_SUB  = 3'b011;
   localparam logic [2:0] ALU_ZERO = 3'b111;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CALC   = 3'd1,
      ACC_LO = 3'd2,
      ACC_HI = 3'd3,
      WRITE  = 3'd4
   } state_e;

endpackage

// File: rtl/alu_mult_seq.sv
// MULT/MULTU sequencer on the shared external ALU, one iteration per cycle; owns HI/LO.
// Define MULT_ACCUM_EN to add the acc input and the MADD/MADDU accumulate states.
module alu_mult_seq
   import alu_mult_seq_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is_signed,
`ifdef MULT_ACCUM_EN
   input  logic             acc,
`endif
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_s,
   output logic             alu_cin,
   input  logic [WIDTH-1:0] alu_d,
   input  logic             alu_cout,
   input  logic             alu_v
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_e             state_q;
   logic [WIDTH-1:0]   m_q;
   logic [WIDTH-1:0]   phi_q;
   logic [WIDTH-1:0]   plo_q;
   logic               q_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               sgn_q;
   logic               busy_q;
   logic               done_q;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;
`ifdef MULT_ACCUM_EN
   logic               acc_q;
   logic               c_q;
`endif

   logic               top_bit;
   logic [WIDTH-1:0]   phi_d;
   logic [WIDTH-1:0]   plo_d;

   // ALU drive is decoded purely from registered state, so the loop through the ALU is one cycle.
   always_comb begin
      alu_a   = '0;
      alu_b   = '0;
      alu_s   = ALU_ZERO;
      alu_cin = 1'b0;
      case (state_q)
         CALC: begin
            alu_a = phi_q;
            alu_s = ALU_ADD;
            if (sgn_q) begin
               case ({plo_q[0], q_q})
                  2'b01: alu_b = m_q;
                  2'b10: begin
                     alu_b   = m_q;
                     alu_s   = ALU_SUB;
                     alu_cin = 1'b1;
                  end
                  default: alu_b = '0;
               endcase
            end else begin
               alu_b = plo_q[0] ? m_q : '0;
            end
         end
`ifdef MULT_ACCUM_EN
         ACC_LO: begin
            alu_a = plo_q;
            alu_b = lo_q;
            alu_s = ALU_ADD;
         end
         ACC_HI: begin
            alu_a   = phi_q;
            alu_b   = hi_q;
            alu_s   = ALU_ADD;
            alu_cin = c_q;
         end
`endif
         default: ;
      endcase
   end

   // Signed: true sign of the 33-bit partial sum is the result MSB corrected by overflow.
   assign top_bit = sgn_q ? (alu_d[WIDTH-1] ^ alu_v) : alu_cout;
   assign phi_d   = {top_bit, alu_d[WIDTH-1:1]};
   assign plo_d   = {alu_d[0], plo_q[WIDTH-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         m_q     <= '0;
         phi_q   <= '0;
         plo_q   <= '0;
         q_q     <= 1'b0;
         cnt_q   <= '0;
         sgn_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
`ifdef MULT_ACCUM_EN
         acc_q   <= 1'b0;
         c_q     <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  m_q     <= op_a;
                  phi_q   <= '0;
                  plo_q   <= op_b;
                  q_q     <= 1'b0;
                  cnt_q   <= '0;
                  sgn_q   <= is_signed;
                  busy_q  <= 1'b1;
`ifdef MULT_ACCUM_EN
                  acc_q   <= acc;
`endif
                  state_q <= CALC;
               end
            end
            CALC: begin
               phi_q <= phi_d;
               plo_q <= plo_d;
               q_q   <= plo_q[0];
               cnt_q <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_LAST) begin
`ifdef MULT_ACCUM_EN
                  if (acc_q) begin
                     state_q <= ACC_LO;
                  end else begin
                     hi_q    <= phi_d;
                     lo_q    <= plo_d;
                     done_q  <= 1'b1;
                     state_q <= WRITE;
                  end
`else
                  // HI/LO load on entry to WRITE so they are valid while done is high.
                  hi_q    <= phi_d;
                  lo_q    <= plo_d;
                  done_q  <= 1'b1;
                  state_q <= WRITE;
`endif
               end
            end
`ifdef MULT_ACCUM_EN
            ACC_LO: begin
               plo_q   <= alu_d;
               c_q     <= alu_cout;
               state_q <= ACC_HI;
            end
            ACC_HI: begin
               phi_q   <= alu_d;
               hi_q    <= alu_d;
               lo_q    <= plo_q;
               done_q  <= 1'b1;
               state_q <= WRITE;
            end
`endif
            WRITE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_alu_mult_seq.sv
// Scoreboard bench for alu_mult_seq with a behavioural 32-bit ALU on the alu_* ports.
// Accumulate vectors run only when MULT_ACCUM_EN is defined.
module tb_alu_mult_seq;
   import alu_mult_seq_pkg::*;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          is_signed = 1'b0;
`ifdef MULT_ACCUM_EN
   logic          acc = 1'b0;
`else
   logic          acc_unused;
`endif
   logic [W-1:0]  op_a = '0;
   logic [W-1:0]  op_b = '0;
   logic          busy, done;
   logic [W-1:0]  hi, lo;
   logic [W-1:0]  alu_a, alu_b, alu_d;
   logic [2:0]    alu_s;
   logic          alu_cin, alu_cout, alu_v;

   logic [W:0]    alu_sum;
   logic [W-1:0]  alu_bop;

   int checks = 0;
   int failures = 0;
   logic [2*W-1:0] sb_q[$];

   always #5 clk = ~clk;

   alu_mult_seq #(.WIDTH(W), .CNT_W(6)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
`ifdef MULT_ACCUM_EN
      .acc(acc),
`endif
      .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .hi(hi), .lo(lo),
      .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_cin(alu_cin),
      .alu_d(alu_d), .alu_cout(alu_cout), .alu_v(alu_v)
   );

   // Shared ALU: a + b + cin for add, a + ~b + cin for subtract, zero otherwise.
   always_comb begin
      alu_bop  = (alu_s == ALU_SUB) ? ~alu_b : alu_b;
      alu_sum  = {1'b0, alu_a} + {1'b0, alu_bop} + {{W{1'b0}}, alu_cin};
      alu_d    = '0;
      alu_cout = 1'b0;
      alu_v    = 1'b0;
      if (alu_s == ALU_ADD || alu_s == ALU_SUB) begin
         alu_d    = alu_sum[W-1:0];
         alu_cout = alu_sum[W];
         alu_v    = alu_sum[W] ^ (alu_sum[W-1] ^ alu_a[W-1] ^ alu_bop[W-1]);
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse pops one expected {hi,lo}.
   always @(negedge clk) begin
      if (rst_n && done) begin
         checks++;
         if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_done: got hi=%h lo=%h expected no result", hi, lo);
         end else begin
            logic [2*W-1:0] exp_v;
            exp_v = sb_q.pop_front();
            if ({hi, lo} !== exp_v) begin
               failures++;
               $display("FAIL result: got hi=%h lo=%h expected hi=%h lo=%h",
                        hi, lo, exp_v[2*W-1:W], exp_v[W-1:0]);
            end else begin
               $display("result ok: hi=%h lo=%h", hi, lo);
            end
         end
      end
   end

   // One multiply: start in the next IDLE cycle, then wait for done within a bound.
   task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input logic ac, input logic [W-1:0] eh, input logic [W-1:0] el,
                          input int reissue);
      int n, nb, lat;
      bit got;
      lat = W + 1;
`ifdef MULT_ACCUM_EN
      acc = ac;
      if (ac) lat = W + 3;
`else
      acc_unused = ac;
`endif
      @(negedge clk);
      op_a = a; op_b = b; is_signed = s; start = 1'b1;
      sb_q.push_back({eh, el});
      $display("issue a=%h b=%h signed=%0b acc=%0b expect hi=%h lo=%h", a, b, s, ac, eh, el);
      @(posedge clk);
      #1;
      start = 1'b0; op_a = ~a; op_b = b ^ 32'h5A5A_A5A5; is_signed = ~s;
      n = 0; nb = 0; got = 0;
      while (!got && n < 100) begin
         @(negedge clk);
         n++;
         if (busy) nb++;
         if (done) got = 1;
         start = (n == reissue);
         if (n == reissue) begin
            op_a = 32'h0000_FFFF; op_b = 32'h0000_FFFF;
         end
      end
      start = 1'b0;
      check("done_latency", 64'(n), 64'(lat));
      check("busy_cycles", 64'(nb), 64'(lat));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish expected finish before timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_hilo", {hi, lo}, 64'd0);
      check("rst_alu_s", 64'(alu_s), 64'(ALU_ZERO));
      check("rst_alu_ab", {alu_a, alu_b}, 64'd0);
      check("rst_alu_cin", 64'(alu_cin), 64'd0);
      rst_n = 1'b1;

      run_mul(32'd7, 32'd6, 1'b0, 1'b0, 32'h0, 32'd42, 0);
      run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001, 0);
      run_mul(32'hFFFF_FFFD, 32'd5, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0);
      run_mul(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 32'h4000_0000, 32'h0, 0);
      run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0, 32'h1, 0);
      run_mul(32'h8000_0000, 32'h1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 0);
      run_mul(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, 32'hC000_0000, 32'h8000_0000, 0);
      // start re-asserted mid-run with other operands must be ignored
      run_mul(32'h1234, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0001_2340, 10);
      // back-to-back: each run_mul starts in the cycle right after the previous done
      run_mul(32'd100, 32'd200, 1'b0, 1'b0, 32'h0, 32'h0000_4E20, 0);
      run_mul(32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 0);

      // start during the WRITE cycle is dropped
      op_a = 32'd9; op_b = 32'd9; is_signed = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      check("write_start_ignored_busy", 64'(busy), 64'd0);
      repeat (3) @(negedge clk);
      check("write_start_ignored_done", 64'(done), 64'd0);

      // asynchronous reset in the middle of CALC
      op_a = 32'd123; op_b = 32'd456; is_signed = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (15) @(negedge clk);
      check("midop_busy_before", 64'(busy), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("midop_rst_busy", 64'(busy), 64'd0);
      check("midop_rst_hilo", {hi, lo}, 64'd0);
      check("midop_rst_alu_s", 64'(alu_s), 64'(ALU_ZERO));
      check("midop_rst_done", 64'(done), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_mul(32'd5, 32'hFFFF_FFF9, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFDD, 0);

`ifdef MULT_ACCUM_EN
      run_mul(32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFF, 0);
      run_mul(32'd1, 32'd1, 1'b0, 1'b1, 32'h1, 32'h0, 0);
      run_mul(32'd1, 32'd5, 1'b0, 1'b0, 32'h0, 32'd5, 0);
      run_mul(32'd2, 32'd3, 1'b0, 1'b1, 32'h0, 32'd11, 0);
`endif

      repeat (3) @(negedge clk);
      check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
